// File: rtl/issue_queue_shift.sv
// Collapsing issue queue: entry DEPTH-1 is oldest, entry 0 takes dispatch.
// Oldest ready entry issues under a ready/valid handshake; holes collapse one slot per cycle.
module issue_queue_shift #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PAYLOAD_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         disp_valid,
    input  logic [TAG_W-1:0]             disp_rs1_tag,
    input  logic [TAG_W-1:0]             disp_rs2_tag,
    input  logic [DATA_W-1:0]            disp_rs1_data,
    input  logic [DATA_W-1:0]            disp_rs2_data,
    input  logic                         disp_rs1_data_valid,
    input  logic                         disp_rs2_data_valid,
    input  logic [PAYLOAD_W-1:0]         disp_payload,
    output logic                         queue_full,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_data,
    input  logic                         flush,
    output logic                         issue_valid,
    output logic [DATA_W-1:0]            issue_rs1_data,
    output logic [DATA_W-1:0]            issue_rs2_data,
    output logic [PAYLOAD_W-1:0]         issue_payload,
    input  logic                         ex_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned SEL_W = $clog2(DEPTH);

    logic [DEPTH-1:0]                w_valid;
    logic [DEPTH-1:0]                w_dv1;
    logic [DEPTH-1:0]                w_dv2;
    logic [DEPTH-1:0][TAG_W-1:0]     w_t1;
    logic [DEPTH-1:0][TAG_W-1:0]     w_t2;
    logic [DEPTH-1:0][DATA_W-1:0]    w_d1;
    logic [DEPTH-1:0][DATA_W-1:0]    w_d2;
    logic [DEPTH-1:0][PAYLOAD_W-1:0] w_pl;

    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_kill;
    logic [DEPTH-1:0] w_shift;
    logic [SEL_W-1:0] w_sel;
    logic [OCC_W-1:0] w_occ;
    logic             w_fire;
    logic             w_disp_acc;
    logic             w_carry;

    // Select: last hit in ascending scan is the highest-index (oldest) ready entry
    always_comb begin
        w_ready = w_valid & w_dv1 & w_dv2;
        w_sel   = '0;
        w_occ   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_ready[i]) w_sel = SEL_W'(i);
            w_occ = w_occ + OCC_W'(w_valid[i]);
        end
    end

    assign issue_valid    = |w_ready;
    assign w_fire         = issue_valid & ex_ready;
    assign occupancy      = w_occ;
    assign queue_full     = (w_occ == OCC_W'(DEPTH));
    assign w_disp_acc     = disp_valid & ~queue_full & ~flush;
    assign issue_rs1_data = issue_valid ? w_d1[w_sel] : '0;
    assign issue_rs2_data = issue_valid ? w_d2[w_sel] : '0;
    assign issue_payload  = issue_valid ? w_pl[w_sel] : '0;

    // Shift chain runs from the oldest slot down: any hole or removal above pulls everything below
    always_comb begin
        w_carry = 1'b0;
        w_kill  = '0;
        w_shift = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            w_kill[i]  = w_fire && (w_sel == SEL_W'(i));
            w_carry    = w_carry | ~w_valid[i] | w_kill[i];
            w_shift[i] = w_carry;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic                 r_valid, r_dv1, r_dv2;
        logic [TAG_W-1:0]     r_t1, r_t2;
        logic [DATA_W-1:0]    r_d1, r_d2;
        logic [PAYLOAD_W-1:0] r_pl;

        logic                 w_s_valid, w_s_dv1, w_s_dv2;
        logic [TAG_W-1:0]     w_s_t1, w_s_t2;
        logic [DATA_W-1:0]    w_s_d1, w_s_d2;
        logic [PAYLOAD_W-1:0] w_s_pl;
        logic                 w_n_dv1, w_n_dv2;
        logic [DATA_W-1:0]    w_n_d1, w_n_d2;

        assign w_valid[g] = r_valid;
        assign w_dv1[g]   = r_dv1;
        assign w_dv2[g]   = r_dv2;
        assign w_t1[g]    = r_t1;
        assign w_t2[g]    = r_t2;
        assign w_d1[g]    = r_d1;
        assign w_d2[g]    = r_d2;
        assign w_pl[g]    = r_pl;

        if (g == 0) begin : g_head
            always_comb begin
                w_s_valid = r_valid;
                w_s_dv1   = r_dv1;
                w_s_dv2   = r_dv2;
                w_s_t1    = r_t1;
                w_s_t2    = r_t2;
                w_s_d1    = r_d1;
                w_s_d2    = r_d2;
                w_s_pl    = r_pl;
                if (w_shift[0]) begin
                    w_s_valid = w_disp_acc;
                    w_s_dv1   = disp_rs1_data_valid;
                    w_s_dv2   = disp_rs2_data_valid;
                    w_s_t1    = disp_rs1_tag;
                    w_s_t2    = disp_rs2_tag;
                    w_s_d1    = disp_rs1_data;
                    w_s_d2    = disp_rs2_data;
                    w_s_pl    = disp_payload;
                end
            end
        end else begin : g_body
            // A neighbour that is issuing this cycle arrives as a hole, not a duplicate
            always_comb begin
                w_s_valid = r_valid;
                w_s_dv1   = r_dv1;
                w_s_dv2   = r_dv2;
                w_s_t1    = r_t1;
                w_s_t2    = r_t2;
                w_s_d1    = r_d1;
                w_s_d2    = r_d2;
                w_s_pl    = r_pl;
                if (w_shift[g]) begin
                    w_s_valid = w_valid[g-1] & ~w_kill[g-1];
                    w_s_dv1   = w_dv1[g-1];
                    w_s_dv2   = w_dv2[g-1];
                    w_s_t1    = w_t1[g-1];
                    w_s_t2    = w_t2[g-1];
                    w_s_d1    = w_d1[g-1];
                    w_s_d2    = w_d2[g-1];
                    w_s_pl    = w_pl[g-1];
                end
            end
        end

        // CDB capture on whatever value lands in this slot
        always_comb begin
            w_n_dv1 = w_s_dv1;
            w_n_d1  = w_s_d1;
            w_n_dv2 = w_s_dv2;
            w_n_d2  = w_s_d2;
            if (!w_s_dv1 && cdb_valid && (w_s_t1 == cdb_tag)) begin
                w_n_dv1 = 1'b1;
                w_n_d1  = cdb_data;
            end
            if (!w_s_dv2 && cdb_valid && (w_s_t2 == cdb_tag)) begin
                w_n_dv2 = 1'b1;
                w_n_d2  = cdb_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_dv1   <= 1'b0;
                r_dv2   <= 1'b0;
                r_t1    <= '0;
                r_t2    <= '0;
                r_d1    <= '0;
                r_d2    <= '0;
                r_pl    <= '0;
            end else begin
                r_valid <= w_s_valid & ~flush;
                r_dv1   <= w_n_dv1;
                r_dv2   <= w_n_dv2;
                r_t1    <= w_s_t1;
                r_t2    <= w_s_t2;
                r_d1    <= w_n_d1;
                r_d2    <= w_n_d2;
                r_pl    <= w_s_pl;
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_shift.sv
// Bench for issue_queue_shift: directed scenarios plus random traffic against an
// age-ordered list model of the queue contents.
module tb_issue_queue_shift;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned TAG_W     = 6;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned PAYLOAD_W = 16;
    localparam int unsigned OCC_W     = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 disp_valid;
    logic [TAG_W-1:0]     disp_rs1_tag, disp_rs2_tag;
    logic [DATA_W-1:0]    disp_rs1_data, disp_rs2_data;
    logic                 disp_rs1_data_valid, disp_rs2_data_valid;
    logic [PAYLOAD_W-1:0] disp_payload;
    logic                 queue_full;
    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;
    logic [DATA_W-1:0]    cdb_data;
    logic                 flush;
    logic                 issue_valid;
    logic [DATA_W-1:0]    issue_rs1_data, issue_rs2_data;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic                 ex_ready;
    logic [OCC_W-1:0]     occupancy;

    issue_queue_shift #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
        .disp_rs1_data_valid(disp_rs1_data_valid), .disp_rs2_data_valid(disp_rs2_data_valid),
        .disp_payload(disp_payload),
        .queue_full(queue_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush),
        .issue_valid(issue_valid),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
        .issue_payload(issue_payload),
        .ex_ready(ex_ready),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: q[0] is the oldest instruction, order is dispatch order
    typedef struct {
        logic [TAG_W-1:0]     t1, t2;
        logic [DATA_W-1:0]    d1, d2;
        logic                 v1, v2;
        logic [PAYLOAD_W-1:0] pl;
    } ent_t;

    ent_t q[$];
    int   n_pass;
    int   n_total;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic ent_t wake(input ent_t e);
        ent_t r = e;
        if (!r.v1 && cdb_valid && r.t1 == cdb_tag) begin r.v1 = 1'b1; r.d1 = cdb_data; end
        if (!r.v2 && cdb_valid && r.t2 == cdb_tag) begin r.v2 = 1'b1; r.d2 = cdb_data; end
        return r;
    endfunction

    task automatic idle();
        disp_valid = 1'b0; disp_rs1_tag = '0; disp_rs2_tag = '0;
        disp_rs1_data = '0; disp_rs2_data = '0;
        disp_rs1_data_valid = 1'b0; disp_rs2_data_valid = 1'b0;
        disp_payload = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        flush = 1'b0; ex_ready = 1'b0;
    endtask

    task automatic disp(input logic [TAG_W-1:0] t1, input logic v1, input logic [DATA_W-1:0] d1,
                        input logic [TAG_W-1:0] t2, input logic v2, input logic [DATA_W-1:0] d2,
                        input logic [PAYLOAD_W-1:0] pl);
        disp_valid = 1'b1;
        disp_rs1_tag = t1; disp_rs1_data_valid = v1; disp_rs1_data = d1;
        disp_rs2_tag = t2; disp_rs2_data_valid = v2; disp_rs2_data = d2;
        disp_payload = pl;
    endtask

    // Called just after a falling edge with inputs applied: compare, advance model, wait a cycle
    task automatic cycle();
        int          sel;
        int          sz;
        logic        iv;
        logic [DATA_W-1:0]    e1, e2;
        logic [PAYLOAD_W-1:0] ep;
        ent_t        e;
        #1;
        sel = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].v1 && q[i].v2) begin sel = i; break; end
        end
        iv = (sel >= 0);
        e1 = '0; e2 = '0; ep = '0;
        if (iv) begin e1 = q[sel].d1; e2 = q[sel].d2; ep = q[sel].pl; end
        sz = q.size();
        chk("issue_valid", 64'(issue_valid), 64'(iv));
        chk("issue_rs1_data", 64'(issue_rs1_data), 64'(e1));
        chk("issue_rs2_data", 64'(issue_rs2_data), 64'(e2));
        chk("issue_payload", 64'(issue_payload), 64'(ep));
        chk("occupancy", 64'(occupancy), 64'(sz));
        chk("queue_full", 64'(queue_full), 64'(sz == int'(DEPTH)));
        if (flush) begin
            q.delete();
        end else begin
            if (iv && ex_ready) q.delete(sel);
            foreach (q[i]) q[i] = wake(q[i]);
            if (disp_valid && sz < int'(DEPTH)) begin
                e.t1 = disp_rs1_tag; e.v1 = disp_rs1_data_valid; e.d1 = disp_rs1_data;
                e.t2 = disp_rs2_tag; e.v2 = disp_rs2_data_valid; e.d2 = disp_rs2_data;
                e.pl = disp_payload;
                q.push_back(wake(e));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        idle();
        rst_n = 1'b0;
        #3;
        chk("reset issue_valid", 64'(issue_valid), 64'(0));
        chk("reset occupancy", 64'(occupancy), 64'(0));
        chk("reset queue_full", 64'(queue_full), 64'(0));
        chk("reset payload", 64'(issue_payload), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Dispatch to issue in one cycle
        idle(); disp(6'd1, 1'b1, 32'd11, 6'd2, 1'b1, 32'd22, 16'h00A5); ex_ready = 1'b1;
        cycle();
        idle(); ex_ready = 1'b1;
        #1;
        chk("t1 issue_valid", 64'(issue_valid), 64'(1));
        chk("t1 payload", 64'(issue_payload), 64'h00A5);
        chk("t1 occupancy", 64'(occupancy), 64'(1));
        cycle();
        #1;
        chk("t1 drained", 64'(occupancy), 64'(0));

        // Fill with tag-5 waiters, then try a fifth dispatch
        for (int k = 0; k < 4; k++) begin
            idle(); disp(6'd5, 1'b0, 32'd0, 6'd3, 1'b1, 32'(k + 100), 16'(k + 1));
            cycle();
        end
        idle(); disp(6'd1, 1'b1, 32'd7, 6'd1, 1'b1, 32'd7, 16'd99);
        #1;
        chk("t2 queue_full", 64'(queue_full), 64'(1));
        chk("t2 occupancy", 64'(occupancy), 64'(4));
        cycle();
        #1;
        chk("t2 occupancy held", 64'(occupancy), 64'(4));

        // Broadcast wakes all four; they drain oldest first
        idle(); cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'h1234;
        cycle();
        idle(); ex_ready = 1'b1;
        #1;
        chk("t3 issue_valid", 64'(issue_valid), 64'(1));
        chk("t3 rs1_data", 64'(issue_rs1_data), 64'h1234);
        chk("t3 oldest payload", 64'(issue_payload), 64'(1));
        for (int k = 0; k < 4; k++) begin
            idle(); ex_ready = 1'b1;
            cycle();
        end
        #1;
        chk("t3 drained", 64'(occupancy), 64'(0));

        // Younger ready entry overtakes a blocked older one
        idle(); disp(6'd7, 1'b0, 32'd0, 6'd1, 1'b1, 32'd1, 16'h000A); cycle();
        idle(); disp(6'd1, 1'b1, 32'hB1, 6'd1, 1'b1, 32'hB2, 16'h000B); cycle();
        idle(); disp(6'd1, 1'b1, 32'hC1, 6'd1, 1'b1, 32'hC2, 16'h000C); cycle();
        idle(); ex_ready = 1'b1;
        #1;
        chk("t4 younger first", 64'(issue_payload), 64'h000B);
        cycle();
        idle(); ex_ready = 1'b1; cycle();
        idle(); ex_ready = 1'b1; cycle();
        #1;
        chk("t4 blocked remains", 64'(occupancy), 64'(1));
        idle(); flush = 1'b1; cycle();

        // Dispatch-cycle CDB bypass
        idle(); disp(6'd1, 1'b1, 32'd5, 6'd9, 1'b0, 32'd0, 16'h0005);
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hBEEF;
        cycle();
        idle();
        #1;
        chk("t5 issue_valid", 64'(issue_valid), 64'(1));
        chk("t5 rs2_data", 64'(issue_rs2_data), 64'hBEEF);
        cycle();

        // Flush with dispatch pending drops everything
        idle(); disp(6'd20, 1'b0, 32'd0, 6'd1, 1'b1, 32'd0, 16'h0021); cycle();
        idle(); disp(6'd20, 1'b0, 32'd0, 6'd1, 1'b1, 32'd0, 16'h0022); cycle();
        idle(); disp(6'd1, 1'b1, 32'd1, 6'd1, 1'b1, 32'd1, 16'h0023); flush = 1'b1;
        cycle();
        idle();
        #1;
        chk("t6 flush occupancy", 64'(occupancy), 64'(0));
        chk("t6 flush issue_valid", 64'(issue_valid), 64'(0));
        cycle();

        // Random traffic with one asynchronous reset in the middle
        for (int n = 0; n < 3000; n++) begin
            idle();
            if ($urandom_range(0, 99) < 60)
                disp(6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom(),
                     6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom(),
                     16'($urandom()));
            cdb_valid = 1'($urandom_range(0, 1));
            cdb_tag   = 6'($urandom_range(0, 7));
            cdb_data  = $urandom();
            flush     = ($urandom_range(0, 99) < 2);
            ex_ready  = ($urandom_range(0, 99) < 60);
            if (n == 1500) begin
                rst_n = 1'b0;
                #1;
                chk("async reset issue_valid", 64'(issue_valid), 64'(0));
                chk("async reset occupancy", 64'(occupancy), 64'(0));
                chk("async reset queue_full", 64'(queue_full), 64'(0));
                chk("async reset rs1_data", 64'(issue_rs1_data), 64'(0));
                q.delete();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/issue_queue_shift.md
# issue_queue_shift

Parametrised, collapsing (shifting) issue queue for one execution unit in the out-of-order back end. It sits between dispatch and the execution unit and holds up to DEPTH instructions with their operand tags and data. It captures results broadcast on the CDB (common data bus) and issues the oldest instruction whose operands are both ready. Unlike the fixed 4-entry control-only generation, this block:
- owns the entry storage;
- is generic in depth and widths;
- uses a ready/valid issue handshake;
- adds flush and occupancy.

## Interface
Parameters:
- DEPTH, 4: number of entries, at least 2. Entry DEPTH-1 is the oldest; entry 0 is the youngest and is written by dispatch.
- TAG_W, 6: physical tag width.
- DATA_W, 32: operand data width.
- PAYLOAD_W, 16: opaque per-instruction payload (opcode, rd tag, …), carried unchanged.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- disp_valid  in  1  dispatch presents an instruction (queue enable).
- disp_rs1_tag / disp_rs2_tag  in  TAG_W  source tags.
- disp_rs1_data / disp_rs2_data  in  DATA_W  operand data; meaningful only when the matching *_data_valid is 1.
- disp_rs1_data_valid / disp_rs2_data_valid  in  1  operand already available.
- disp_payload  in  PAYLOAD_W  payload.
- queue_full  out  1  back-pressure: all entries are valid.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  DATA_W  broadcast data.
- flush  in  1  synchronous kill of all entries.
- issue_valid  out  1  an entry is ready.
- issue_rs1_data / issue_rs2_data  out  DATA_W  operands of the selected entry.
- issue_payload  out  PAYLOAD_W  payload of the selected entry.
- ex_ready  in  1  execution unit accepts the issue this cycle.
- occupancy  out  $clog2(DEPTH+1)  count of valid entries.

## Operation
Each entry holds: valid, rs1/rs2 tag, rs1/rs2 data, rs1/rs2 data_valid, payload. An entry is ready when it is valid and both data_valid bits are 1.

Select:
- The highest-index ready entry is selected.
- issue_valid = any entry ready.
- Issue outputs are combinational from the selected entry; they are all-zero when issue_valid=0.

Issue fire:
- fire = issue_valid & ex_ready.
- The selected entry is removed at the next edge.
- While ex_ready=0 the selection may change to a newly ready, older entry. The execution unit samples only on fire.

Shift: entry i loads entry i-1 (entry 0 loads dispatch) when shift[i] = 1.
- shift[DEPTH-1] = ~valid[DEPTH-1] | (fire & sel==DEPTH-1).
- shift[i] = shift[i+1] | ~valid[i] | (fire & sel==i).
- If shift[i] = 0, entry i holds.

Holes and dispatch:
- Holes collapse by one position per cycle.
- An entry receiving an invalid neighbour becomes invalid.

Dispatch:
- Accepted iff disp_valid & ~queue_full & ~flush.
- When shift[0]=1 and no dispatch is accepted, entry 0 becomes invalid.
- Whenever queue_full=0, shift[0]=1 holds by construction.

Wakeup:
- For every operand with data_valid=0 and cdb_valid & tag==cdb_tag: data←cdb_data and data_valid←1.
- The capture applies to the value being written into the entry, whether the entry holds, shifts in, or is loaded from dispatch (CDB bypass on all paths).
- Operands with data_valid=1 are never overwritten.
- rs1 and rs2 may wake in the same cycle.

Flush:
- At the next edge all valid bits are cleared.
- Flush overrides dispatch, fire-removal and wakeup.
- fire is still reported combinationally in the flush cycle; the execution unit owns discarding it.

Derived outputs:
- occupancy = popcount(valid), combinational from registers.
- queue_full = (occupancy == DEPTH).

Reset (rst_n=0, asynchronous):
- All valid, data_valid, tag, data and payload registers are cleared to 0.
- Outputs during and after reset: queue_full=0, issue_valid=0, issue data/payload=0, occupancy=0.
- Reset asserted mid-operation discards all entries immediately; there is no partial state.

## Timing
- Dispatch to issue: an instruction accepted at edge N with both operands valid drives issue_valid=1 in cycle N+1 from entry 0.
- Wakeup to issue: a CDB match at edge N makes the entry eligible in cycle N+1. There is no same-cycle CDB-to-issue path.
- Dispatch with CDB bypass: an operand matched by the CDB in the dispatch cycle is stored valid.
- Throughput: one dispatch and one issue per cycle. When full, fire at edge N also permits a dispatch at edge N+1; queue_full is registered-derived and deasserts after the removal.
- Select and shift are combinational. The critical path is select → shift chain over DEPTH entries.

## Test plan
1. Reset, then dispatch with both operands valid, payload=0x00A5, ex_ready=1 → issue_valid=1 one cycle later with payload 0x00A5; occupancy goes 1 then 0.
2. DEPTH=4: dispatch 4 entries with rs1_tag=5 not ready, ex_ready=0 → queue_full=1 and occupancy=4. A fifth disp_valid is not accepted; occupancy stays 4.
3. Full queue, cdb_valid with cdb_tag=5, cdb_data=0x1234 → all 4 wake. Next cycle issue_valid=1 with rs1_data=0x1234 from entry 3 (oldest). Entries issue in dispatch order with ex_ready=1.
4. Entry 2 (younger) ready and entry 3 not ready → entry 2 issues first. Entry 3 then shifts into no slot (stays) while entries 1..0 collapse up by one per cycle.
5. Dispatch with rs2_tag=9 not ready while the CDB broadcasts tag 9/data 0xBEEF the same cycle → entry stored with rs2 valid, rs2_data=0xBEEF; issue_valid=1 the next cycle.
6. Flush with 3 entries and disp_valid=1 → next cycle occupancy=0 and issue_valid=0, and the dispatched instruction is dropped. Asserting rst_n=0 mid-stream clears all outputs asynchronously.
